// File: rtl/qword_mem_bridge_pkg.sv
// Shared definitions for the qword memory bridge: FSM states, bus geometry and
// a helper that extracts one 32-bit word from a qword.
package qword_mem_bridge_pkg;

    localparam int unsigned BUS_DATA_WIDTH_SHIFT = 4;
    localparam int unsigned BUS_DATA_WIDTH       = 128;
    localparam int unsigned WORD_PER_QWORD       = 4;
    localparam int unsigned BEAT_WIDTH           = 2;
    localparam int unsigned WORD_WIDTH           = BUS_DATA_WIDTH / WORD_PER_QWORD;

    typedef enum logic [1:0] {
        StIdle,
        StBeat,
        StResp,
        StDrain
    } bridge_state_e;

    // Word idx of a qword; word i occupies bits [32i+31:32i].
    function automatic logic [WORD_WIDTH-1:0] qword_word(
        input logic [BUS_DATA_WIDTH-1:0] q,
        input logic [BEAT_WIDTH-1:0]     idx
    );
        return q[{idx, 5'b0} +: WORD_WIDTH];
    endfunction

endpackage

// File: rtl/qword_mem_bridge_increment.sv
// Combinational incrementer; carry_o flags wrap from all-ones back to zero.
module increment #(
    parameter int unsigned DATA_WIDTH = 2
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  carry_o
);

    // Sum and carry out of data_i + 1.
    always_comb begin
        {carry_o, data_o} = {1'b0, data_i} + {{DATA_WIDTH{1'b0}}, 1'b1};
    end

endmodule

// File: rtl/qword_mem_bridge.sv
// qword_mem_bridge: splits one 128-bit cache request into four ascending 32-bit
// memory beats and returns a one-cycle completion pulse with the read qword.
// Optional feature macro: QWORD_BRIDGE_TIMEOUT_EN (per-beat ack timeout, err_o).
module qword_mem_bridge
    import qword_mem_bridge_pkg::*;
#(
    parameter int unsigned BUS_ADDRESS_WIDTH = 20,
    parameter int unsigned TIMEOUT_CYCLES    = 255
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic                                          req_valid_i,
    input  logic [BUS_ADDRESS_WIDTH-BUS_DATA_WIDTH_SHIFT-1:0] req_addr_i,
    input  logic                                          req_we_i,
    input  logic [BUS_DATA_WIDTH-1:0]                     req_wdata_i,
    output logic                                          resp_valid_o,
    output logic [BUS_DATA_WIDTH-1:0]                     resp_rdata_o,
    output logic                                          busy_o,
    output logic                                          err_o,
    output logic                                          mem_req_o,
    output logic                                          mem_we_o,
    output logic [BUS_ADDRESS_WIDTH-3:0]                  mem_addr_o,
    output logic [WORD_WIDTH-1:0]                         mem_wdata_o,
    input  logic [WORD_WIDTH-1:0]                         mem_rdata_i,
    input  logic                                          mem_ack_i
);

    localparam int unsigned QADDR_WIDTH = BUS_ADDRESS_WIDTH - BUS_DATA_WIDTH_SHIFT;

    bridge_state_e                   state_q, state_d;
    logic [BEAT_WIDTH-1:0]           beat_q, beat_d;
    logic [BEAT_WIDTH-1:0]           beat_inc;
    logic                            beat_last;
    logic [QADDR_WIDTH-1:0]          qaddr_q, qaddr_d;
    logic                            we_q, we_d;
    logic [BUS_DATA_WIDTH-1:0]       wdata_q, wdata_d;
    logic [BUS_DATA_WIDTH-1:0]       rbuf_q, rbuf_d;
    logic [BUS_DATA_WIDTH-1:0]       rdata_q, rdata_d;
    logic                            beat_active;
    logic                            beat_timeout;
    logic                            beat_done;

    // Beat counter; its carry marks completion of the last beat.
    increment #(
        .DATA_WIDTH (BEAT_WIDTH)
    ) u_beat_inc (
        .data_i  (beat_q),
        .data_o  (beat_inc),
        .carry_o (beat_last)
    );

    assign beat_active = (state_q == StBeat);
    // Acks outside StBeat are ignored; a timed-out beat completes like an acked one.
    assign beat_done   = beat_active && (mem_ack_i || beat_timeout);

`ifdef QWORD_BRIDGE_TIMEOUT_EN
    localparam int unsigned WAIT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    logic [WAIT_WIDTH-1:0] wait_q, wait_d;
    logic                  err_q, err_d;

    // Count no-ack cycles of the current beat; the TIMEOUT_CYCLES-th one abandons it.
    always_comb begin
        wait_d       = '0;
        beat_timeout = 1'b0;
        if (beat_active && !mem_ack_i) begin
            if (wait_q == WAIT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                beat_timeout = 1'b1;
            end else begin
                wait_d = wait_q + 1'b1;
            end
        end
        err_d = err_q | beat_timeout;
    end

    // Wait counter and sticky error flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wait_q <= wait_d;
            err_q  <= err_d;
        end
    end

    assign err_o = err_q;
`else
    // Without the timeout the parameter has no effect.
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;

    assign beat_timeout = 1'b0;
    assign err_o        = 1'b0;
`endif

    // Next-state and datapath updates for the request/beat/response sequence.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        qaddr_d = qaddr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rbuf_d  = rbuf_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    qaddr_d = req_addr_i;
                    we_d    = req_we_i;
                    wdata_d = req_wdata_i;
                    beat_d  = '0;
                    state_d = StBeat;
                end
            end
            StBeat: begin
                if (beat_done) begin
                    beat_d = beat_inc;
                    if (!we_q) begin
                        rbuf_d[{beat_q, 5'b0} +: WORD_WIDTH] =
                            mem_ack_i ? mem_rdata_i : '0;
                    end
                    if (beat_last) begin
                        state_d = StResp;
                        // Publish the read qword so it is valid alongside resp_valid_o.
                        if (!we_q) begin
                            rdata_d = rbuf_d;
                        end
                    end
                end
            end
            StResp: begin
                state_d = StDrain;
            end
            StDrain: begin
                // A valid still held from the finished request must not start another.
                if (!req_valid_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset aborts any transfer in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            beat_q  <= '0;
            qaddr_q <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rbuf_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            qaddr_q <= qaddr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rbuf_q  <= rbuf_d;
            rdata_q <= rdata_d;
        end
    end

    // Outputs decode from registered state so reset removes them immediately.
    always_comb begin
        resp_valid_o = (state_q == StResp);
        busy_o       = (state_q != StIdle);
        resp_rdata_o = rdata_q;
        mem_req_o    = beat_active;
        mem_we_o     = beat_active && we_q;
        mem_addr_o   = beat_active ? {qaddr_q, beat_q} : '0;
        mem_wdata_o  = (beat_active && we_q) ? qword_word(wdata_q, beat_q) : '0;
    end

endmodule

// File: tb/tb_qword_mem_bridge.sv
// Directed self-checking bench for qword_mem_bridge.
// Exercises the QWORD_BRIDGE_TIMEOUT_EN path only when that macro is defined.
module tb_qword_mem_bridge;

`ifdef QWORD_BRIDGE_TIMEOUT_EN
    localparam int unsigned TO_CYCLES = 4;
`else
    localparam int unsigned TO_CYCLES = 255;
`endif

    logic          clk_i;
    logic          rst_ni;
    logic          req_valid_i;
    logic [15:0]   req_addr_i;
    logic          req_we_i;
    logic [127:0]  req_wdata_i;
    logic          resp_valid_o;
    logic [127:0]  resp_rdata_o;
    logic          busy_o;
    logic          err_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [17:0]   mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic [31:0]   mem_rdata_i;
    logic          mem_ack_i;

    logic [31:0]   mem_words [4];
    logic [127:0]  exp_q;
    logic [127:0]  wdata_v;
    int            n_vec;
    int            n_miss;

    qword_mem_bridge #(
        .BUS_ADDRESS_WIDTH (20),
        .TIMEOUT_CYCLES    (TO_CYCLES)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_addr_i   (req_addr_i),
        .req_we_i     (req_we_i),
        .req_wdata_i  (req_wdata_i),
        .resp_valid_o (resp_valid_o),
        .resp_rdata_o (resp_rdata_o),
        .busy_o       (busy_o),
        .err_o        (err_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_ack_i    (mem_ack_i)
    );

    // Memory model: the word selected by the beat index of the address.
    assign mem_rdata_i = mem_words[mem_addr_o[1:0]];

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check_vec(input string tag, input logic [127:0] got,
                             input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_words(input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3);
        mem_words[0] = w0;
        mem_words[1] = w1;
        mem_words[2] = w2;
        mem_words[3] = w3;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_vec({tag, "_req"},   128'(mem_req_o),    128'h0);
        check_vec({tag, "_we"},    128'(mem_we_o),     128'h0);
        check_vec({tag, "_addr"},  128'(mem_addr_o),   128'h0);
        check_vec({tag, "_wdata"}, 128'(mem_wdata_o),  128'h0);
        check_vec({tag, "_rvld"},  128'(resp_valid_o), 128'h0);
        check_vec({tag, "_busy"},  128'(busy_o),       128'h0);
        check_vec({tag, "_err"},   128'(err_o),        128'h0);
    endtask

    initial begin
        n_vec       = 0;
        n_miss      = 0;
        rst_ni      = 1'b0;
        req_valid_i = 1'b0;
        req_addr_i  = '0;
        req_we_i    = 1'b0;
        req_wdata_i = '0;
        mem_ack_i   = 1'b0;
        set_words(32'h0, 32'h0, 32'h0, 32'h0);

        // Reset state.
        #12;
        check_idle_outputs("rst");
        check_vec("rst_rdata", resp_rdata_o, 128'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();

        // Spurious ack in idle: nothing starts, nothing is captured.
        set_words(32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
        mem_ack_i = 1'b1;
        repeat (3) step();
        check_idle_outputs("spur");
        check_vec("spur_rdata", resp_rdata_o, 128'h0);

        // Read with ack tied high; valid dropped and address changed after accept.
        set_words(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
        req_addr_i  = 16'h0123;
        req_we_i    = 1'b0;
        req_wdata_i = {4{32'h0BAD0BAD}};
        req_valid_i = 1'b1;
        step();
        req_valid_i = 1'b0;
        req_addr_i  = 16'hFFFF;
        for (int b = 0; b < 4; b++) begin
            check_vec("rd_req",  128'(mem_req_o),    128'h1);
            check_vec("rd_we",   128'(mem_we_o),     128'h0);
            check_vec("rd_addr", 128'(mem_addr_o),   128'h48C + 128'(b));
            check_vec("rd_rvld", 128'(resp_valid_o), 128'h0);
            step();
        end
        exp_q = 128'h44444444_33333333_22222222_11111111;
        check_vec("rd_resp",  128'(resp_valid_o), 128'h1);
        check_vec("rd_rdata", resp_rdata_o,       exp_q);
        check_vec("rd_req5",  128'(mem_req_o),    128'h0);
        check_vec("rd_busy5", 128'(busy_o),       128'h1);
        step();
        check_vec("rd_resp6", 128'(resp_valid_o), 128'h0);
        check_vec("rd_busy6", 128'(busy_o),       128'h1);
        step();
        check_vec("rd_busy7", 128'(busy_o),       128'h0);

        // Write-back at the top qword address, ack low every other cycle, valid held.
        set_words(32'h55555555, 32'h55555555, 32'h55555555, 32'h55555555);
        wdata_v     = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        req_addr_i  = 16'hFFFF;
        req_we_i    = 1'b1;
        req_wdata_i = wdata_v;
        req_valid_i = 1'b1;
        mem_ack_i   = 1'b0;
        step();
        for (int c = 0; c < 8; c++) begin
            mem_ack_i = (c % 2 == 1);
            check_vec("wr_we",    128'(mem_we_o),     128'h1);
            check_vec("wr_addr",  128'(mem_addr_o),   128'h3FFFC + 128'(c / 2));
            check_vec("wr_wdata", 128'(mem_wdata_o),  (wdata_v >> (32 * (c / 2))) & 128'hFFFFFFFF);
            check_vec("wr_rvld",  128'(resp_valid_o), 128'h0);
            step();
        end
        mem_ack_i = 1'b0;
        check_vec("wr_resp",  128'(resp_valid_o), 128'h1);
        check_vec("wr_rdata", resp_rdata_o,       exp_q);

        // Valid still high: stay drained, no second pulse, no new beat.
        for (int k = 0; k < 3; k++) begin
            step();
            check_vec("hold_rvld", 128'(resp_valid_o), 128'h0);
            check_vec("hold_req",  128'(mem_req_o),    128'h0);
            check_vec("hold_busy", 128'(busy_o),       128'h1);
        end
        req_valid_i = 1'b0;
        step();
        check_vec("hold_idle", 128'(busy_o),    128'h0);
        check_vec("hold_req2", 128'(mem_req_o), 128'h0);

        // Read interrupted by reset during beat 2.
        req_addr_i  = 16'h0ABC;
        req_we_i    = 1'b0;
        req_valid_i = 1'b1;
        mem_ack_i   = 1'b1;
        step();
        req_valid_i = 1'b0;
        check_vec("ab_addr0", 128'(mem_addr_o), 128'h2AF0);
        step();
        step();
        check_vec("ab_addr2", 128'(mem_addr_o), 128'h2AF2);
        #2;
        rst_ni = 1'b0;
        #1;
        check_idle_outputs("ab");
        check_vec("ab_rdata", resp_rdata_o, 128'h0);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        check_vec("ab_rvld", 128'(resp_valid_o), 128'h0);

        // Next request after the abort starts again at beat 0.
        set_words(32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3);
        req_addr_i  = 16'h0002;
        req_valid_i = 1'b1;
        step();
        req_valid_i = 1'b0;
        for (int b = 0; b < 4; b++) begin
            check_vec("re_addr", 128'(mem_addr_o), 128'h8 + 128'(b));
            step();
        end
        check_vec("re_resp",  128'(resp_valid_o), 128'h1);
        check_vec("re_rdata", resp_rdata_o, 128'hD3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0A0);
        step();
        step();

`ifdef QWORD_BRIDGE_TIMEOUT_EN
        // Ack withheld on beat 1: abandoned after 4 cycles, word forced to zero.
        set_words(32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10);
        req_addr_i  = 16'h0010;
        req_valid_i = 1'b1;
        mem_ack_i   = 1'b1;
        step();
        req_valid_i = 1'b0;
        check_vec("to_addr0", 128'(mem_addr_o), 128'h40);
        step();
        mem_ack_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_vec("to_addr1", 128'(mem_addr_o), 128'h41);
            check_vec("to_err0",  128'(err_o),      128'h0);
            step();
        end
        mem_ack_i = 1'b1;
        check_vec("to_addr2", 128'(mem_addr_o), 128'h42);
        check_vec("to_err1",  128'(err_o),      128'h1);
        step();
        check_vec("to_addr3", 128'(mem_addr_o), 128'h43);
        step();
        check_vec("to_resp",  128'(resp_valid_o), 128'h1);
        check_vec("to_rdata", resp_rdata_o, 128'h0D0E0F10_090A0B0C_00000000_01020304);
        step();
        check_vec("to_sticky", 128'(err_o), 128'h1);
`else
        check_vec("no_err", 128'(err_o), 128'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
